// File: rtl/sample_voice_scheduler.sv
// rtl/sample_voice_scheduler.sv - round-robin-free, lowest-index-first voice scheduler for a shared sample datapath
// Optional overrun counter output enabled by SAMPLE_SCHED_OVERRUN_CNT_EN.
module sample_voice_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int VOICE_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_pulse,
    input  logic [NUM_VOICES-1:0] voice_en,
    output logic                  dp_req,
    output logic [VOICE_W-1:0]    dp_voice,
    input  logic                  dp_ack,
    output logic                  sample_done,
    output logic                  busy,
    output logic                  overrun
`ifdef SAMPLE_SCHED_OVERRUN_CNT_EN
    ,
    output logic [7:0]            overrun_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [NUM_VOICES-1:0] r_pending;
    logic [VOICE_W-1:0]    r_voice;
    logic                  r_dp_req;
    logic                  r_done;
    logic                  r_busy;
    logic                  r_overrun;
    logic [NUM_VOICES-1:0] w_remain;
    logic                  w_drop;

    function automatic logic [VOICE_W-1:0] f_lowest(input logic [NUM_VOICES-1:0] m);
        f_lowest = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (m[i]) f_lowest = VOICE_W'(i);
        end
    endfunction

    // Pending voices left once the currently requested voice is acknowledged.
    assign w_remain = r_pending & ~(NUM_VOICES'(1) << r_voice);
    assign w_drop   = sample_pulse && (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pending <= '0;
            r_voice   <= '0;
            r_dp_req  <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_drop;
            r_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (sample_pulse) begin
                        r_pending <= voice_en;
                        r_busy    <= 1'b1;
                        if (|voice_en) begin
                            r_state  <= S_REQ;
                            r_dp_req <= 1'b1;
                            r_voice  <= f_lowest(voice_en);
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (dp_ack) begin
                        r_pending <= w_remain;
                        if (|w_remain) begin
                            r_voice <= f_lowest(w_remain);
                        end else begin
                            r_state  <= S_DONE;
                            r_dp_req <= 1'b0;
                            r_done   <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_dp_req <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

`ifdef SAMPLE_SCHED_OVERRUN_CNT_EN
    logic [7:0] r_overrun_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun_cnt <= 8'd0;
        end else if (w_drop && (r_overrun_cnt != 8'd255)) begin
            r_overrun_cnt <= r_overrun_cnt + 8'd1;
        end
    end

    assign overrun_cnt = r_overrun_cnt;
`endif

    assign dp_req      = r_dp_req;
    assign dp_voice    = r_voice;
    assign sample_done = r_done;
    assign busy        = r_busy;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_sample_voice_scheduler.sv
// tb/tb_sample_voice_scheduler.sv - randomized self-checking bench for sample_voice_scheduler
module tb_sample_voice_scheduler;
    localparam int NV = 4;
    localparam int VW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          sample_pulse;
    logic [NV-1:0] voice_en;
    logic          dp_req;
    logic [VW-1:0] dp_voice;
    logic          dp_ack;
    logic          sample_done;
    logic          busy;
    logic          overrun;
`ifdef SAMPLE_SCHED_OVERRUN_CNT_EN
    logic [7:0]    overrun_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sample_voice_scheduler #(.NUM_VOICES(NV), .VOICE_W(VW)) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_pulse(sample_pulse),
        .voice_en    (voice_en),
        .dp_req      (dp_req),
        .dp_voice    (dp_voice),
        .dp_ack      (dp_ack),
        .sample_done (sample_done),
        .busy        (busy),
        .overrun     (overrun)
`ifdef SAMPLE_SCHED_OVERRUN_CNT_EN
        ,
        .overrun_cnt (overrun_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; sample_pulse = 1'b0; dp_ack = 1'b0; voice_en = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Expected frame: ascending list of set bits of the latched mask, one request each,
    // held until acknowledged, then one DONE cycle, then IDLE.
    task automatic run_frame(input logic [NV-1:0] mask, input int delay, input string tag);
        int q[$];
        int d;
        logic [6:0] got7, exp7;
        logic [3:0] got4, exp4;
        for (int i = 0; i < NV; i++) if (mask[i]) q.push_back(i);
        sample_pulse = 1'b1; voice_en = mask; dp_ack = 1'($urandom);
        tick();
        sample_pulse = 1'b0;
        foreach (q[n]) begin
            d = (delay < 0) ? int'($urandom_range(3, 0)) : delay;
            for (int j = 0; j <= d; j++) begin
                voice_en = NV'($urandom);
                dp_ack   = (j == d);
                got7 = {dp_req, dp_voice, sample_done, busy, overrun, 1'b0};
                exp7 = {1'b1, VW'(q[n]), 1'b0, 1'b1, 1'b0, 1'b0};
                vectors++;
                if (got7 !== exp7) begin
                    miscompares++;
                    $display("FAIL %s req voice%0d wait%0d: got {req,voice,done,busy,ovr}=%b want %b",
                             tag, q[n], j, got7[6:1], exp7[6:1]);
                end
                tick();
            end
        end
        dp_ack = 1'($urandom);
        got4 = {dp_req, sample_done, busy, overrun};
        exp4 = 4'b0110;
        vectors++;
        if (got4 !== exp4) begin
            miscompares++;
            $display("FAIL %s done: got {req,done,busy,ovr}=%b want %b", tag, got4, exp4);
        end
        tick();
        dp_ack = 1'($urandom);
        got4 = {dp_req, sample_done, busy, overrun};
        vectors++;
        if (got4 !== 4'b0000) begin
            miscompares++;
            $display("FAIL %s idle_after: got {req,done,busy,ovr}=%b want 0000", tag, got4);
        end
    endtask

    task automatic test_reset();
        logic [5:0] got;
        rst = 1'b0; sample_pulse = 1'b0; dp_ack = 1'b0; voice_en = '0;
        #2 rst = 1'b1;
        #1;
        got = {dp_req, dp_voice, sample_done, busy, overrun};
        vectors++;
        if (got !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_state: got {req,voice,done,busy,ovr}=%b want 000000", got);
        end
        tick();
        rst = 1'b0;
        voice_en = 4'b1111; dp_ack = 1'b1;
        tick();
        got = {dp_req, dp_voice, sample_done, busy, overrun};
        vectors++;
        if (got !== 6'b0) begin
            miscompares++;
            $display("FAIL idle_ignores_inputs: got %b want 000000", got);
        end
    endtask

    task automatic test_directed();
        run_frame(4'b1011, 2, "mask1011_ack2");
        run_frame(4'b0000, 0, "empty_mask");
        run_frame(4'b1111, 0, "ack_tied_high");
        run_frame(4'b1000, 1, "single_top_voice");
    endtask

    task automatic test_random();
        for (int f = 0; f < 40; f++) begin
            run_frame(NV'($urandom), -1, "random_frame");
            for (int g = 0; g < int'($urandom_range(2, 0)); g++) begin
                sample_pulse = 1'b0; voice_en = NV'($urandom); dp_ack = 1'($urandom);
                tick();
                vectors++;
                if ({dp_req, sample_done, busy, overrun} !== 4'b0000) begin
                    miscompares++;
                    $display("FAIL random_gap: got {req,done,busy,ovr}=%b want 0000",
                             {dp_req, sample_done, busy, overrun});
                end
            end
        end
    endtask

    task automatic test_overrun();
        do_reset();
`ifdef SAMPLE_SCHED_OVERRUN_CNT_EN
        vectors++;
        if (overrun_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL ovr_cnt_reset: got %0d want 0", overrun_cnt);
        end
`endif
        sample_pulse = 1'b1; voice_en = 4'b0011;
        tick();
        sample_pulse = 1'b1; dp_ack = 1'b0;
        tick();
        sample_pulse = 1'b0;
        vectors++;
        if ({overrun, dp_req, dp_voice} !== 4'b1100) begin
            miscompares++;
            $display("FAIL overrun_pulse: got {ovr,req,voice}=%b want 1100", {overrun, dp_req, dp_voice});
        end
`ifdef SAMPLE_SCHED_OVERRUN_CNT_EN
        vectors++;
        if (overrun_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL ovr_cnt_first: got %0d want 1", overrun_cnt);
        end
`endif
        tick();
        vectors++;
        if ({overrun, dp_req, dp_voice} !== 4'b0100) begin
            miscompares++;
            $display("FAIL overrun_one_cycle: got {ovr,req,voice}=%b want 0100", {overrun, dp_req, dp_voice});
        end
        dp_ack = 1'b1;
        tick();
        vectors++;
        if ({dp_req, dp_voice} !== 3'b101) begin
            miscompares++;
            $display("FAIL overrun_second_voice: got {req,voice}=%b want 101", {dp_req, dp_voice});
        end
        tick();
        dp_ack = 1'b0;
        vectors++;
        if ({dp_req, sample_done} !== 2'b01) begin
            miscompares++;
            $display("FAIL overrun_done: got {req,done}=%b want 01", {dp_req, sample_done});
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if ({dp_req, sample_done, busy} !== 3'b000) begin
                miscompares++;
                $display("FAIL no_extra_frame: got {req,done,busy}=%b want 000", {dp_req, sample_done, busy});
            end
        end
    endtask

    task automatic test_done_boundary();
        do_reset();
        sample_pulse = 1'b1; voice_en = 4'b0000;
        tick();
        sample_pulse = 1'b1; voice_en = 4'b0001;
        tick();
        vectors++;
        if ({dp_req, sample_done, busy, overrun} !== 4'b0001) begin
            miscompares++;
            $display("FAIL done_pulse_overrun: got {req,done,busy,ovr}=%b want 0001",
                     {dp_req, sample_done, busy, overrun});
        end
        sample_pulse = 1'b1; voice_en = 4'b0100;
        tick();
        sample_pulse = 1'b0; dp_ack = 1'b1;
        vectors++;
        if ({dp_req, dp_voice, busy, overrun} !== 5'b11010) begin
            miscompares++;
            $display("FAIL pulse_after_done_accepted: got {req,voice,busy,ovr}=%b want 11010",
                     {dp_req, dp_voice, busy, overrun});
        end
        tick();
        dp_ack = 1'b0;
        vectors++;
        if ({dp_req, sample_done} !== 2'b01) begin
            miscompares++;
            $display("FAIL boundary_frame_done: got {req,done}=%b want 01", {dp_req, sample_done});
        end
        tick();
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        sample_pulse = 1'b1; voice_en = 4'b0111; dp_ack = 1'b1;
        tick();
        sample_pulse = 1'b0;
        tick();
        tick();
        dp_ack = 1'b0;
        vectors++;
        if ({dp_req, dp_voice} !== 3'b110) begin
            miscompares++;
            $display("FAIL pre_reset_voice: got {req,voice}=%b want 110", {dp_req, dp_voice});
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({dp_req, busy, sample_done} !== 3'b000) begin
            miscompares++;
            $display("FAIL async_reset_mid_frame: got {req,busy,done}=%b want 000", {dp_req, busy, sample_done});
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if ({dp_req, busy, sample_done} !== 3'b000) begin
                miscompares++;
                $display("FAIL abandoned_frame: got {req,busy,done}=%b want 000", {dp_req, busy, sample_done});
            end
        end
        run_frame(4'b0110, -1, "restart_after_reset");
    endtask

    task automatic test_mask_change();
        do_reset();
        sample_pulse = 1'b1; voice_en = 4'b0011;
        tick();
        sample_pulse = 1'b0;
        voice_en = 4'b1100;
        dp_ack = 1'b1;
        for (int v = 0; v < 2; v++) begin
            vectors++;
            if ({dp_req, dp_voice} !== {1'b1, VW'(v)}) begin
                miscompares++;
                $display("FAIL mask_latched voice%0d: got {req,voice}=%b want %b", v, {dp_req, dp_voice}, {1'b1, VW'(v)});
            end
            tick();
        end
        dp_ack = 1'b0;
        vectors++;
        if ({dp_req, sample_done} !== 2'b01) begin
            miscompares++;
            $display("FAIL mask_latched_done: got {req,done}=%b want 01", {dp_req, sample_done});
        end
        tick();
        run_frame(4'b1100, 1, "next_frame_new_mask");
    endtask

    task automatic test_overrun_sat();
        do_reset();
        sample_pulse = 1'b1; voice_en = 4'b0001; dp_ack = 1'b0;
        tick();
        for (int k = 0; k < 300; k++) begin
            sample_pulse = 1'b1;
            tick();
            vectors++;
            if ({overrun, dp_req, dp_voice} !== 4'b1100) begin
                miscompares++;
                $display("FAIL sustained_overrun %0d: got {ovr,req,voice}=%b want 1100", k, {overrun, dp_req, dp_voice});
            end
`ifdef SAMPLE_SCHED_OVERRUN_CNT_EN
            vectors++;
            if (overrun_cnt !== ((k + 1 > 255) ? 8'd255 : 8'(k + 1))) begin
                miscompares++;
                $display("FAIL ovr_cnt_sat %0d: got %0d want %0d", k, overrun_cnt, (k + 1 > 255) ? 255 : k + 1);
            end
`endif
        end
        sample_pulse = 1'b0;
        tick();
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_stops: got %b want 0", overrun);
        end
        do_reset();
`ifdef SAMPLE_SCHED_OVERRUN_CNT_EN
        vectors++;
        if (overrun_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL ovr_cnt_cleared: got %0d want 0", overrun_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_overrun();
        test_done_boundary();
        test_reset_mid_frame();
        test_mask_change();
        test_overrun_sat();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
